// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction sequencer and the control decoder:
// opcode values, the datapath opcode set, field layout and the sequencer state type.
package isa_pkg;

  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] OPC_NOP  = 4'b0111;
  localparam logic [OPC_W-1:0] OPC_JMP  = 4'b1100;
  localparam logic [OPC_W-1:0] OPC_JZ   = 4'b1101;
  localparam logic [OPC_W-1:0] OPC_HALT = 4'b1111;

  // Bit i set when opcode i is handled by the datapath (everything but NOP/JMP/JZ/HALT)
  localparam logic [15:0] DATAPATH_OPS = 16'h4F7F;

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_ISSUE,
    S_EXEC,
    S_HALTED
  } seq_state_t;

  function automatic logic is_datapath_op(input logic [OPC_W-1:0] op);
    return DATAPATH_OPS[op];
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: synchronous load/increment, modulo 2^AW, async reset to RESET_PC.
module pc_counter #(
  parameter int unsigned AW       = 12,
  parameter int unsigned RESET_PC = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          inc,
  input  logic [AW-1:0] load_val,
  output logic [AW-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= AW'(RESET_PC);
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + AW'(1);
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetches instruction words, resolves jumps/halt locally and issues datapath opcodes.
// Outputs are registered: each state's output actions become visible on the following cycle.
module instr_sequencer
  import isa_pkg::*;
#(
  parameter int unsigned AW          = 12,
  parameter int unsigned DW          = 16,
  parameter int unsigned EXEC_CYCLES = 1,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [AW-1:0]    imem_addr,
  output logic             imem_rd,
  input  logic [DW-1:0]    imem_data,
  input  logic             zero,
  input  logic             stall,
  output logic [OPC_W-1:0] opr,
  output logic [AW-1:0]    operand,
  output logic             halt,
  output logic [AW-1:0]    pc
);

  localparam int unsigned CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  seq_state_t       state;
  logic [CW-1:0]    exec_cnt;
  logic [OPC_W-1:0] op_q;
  logic [AW-1:0]    opd_q;
  logic [OPC_W-1:0] word_opc;
  logic [AW-1:0]    word_opd;
  logic             pc_load;
  logic             pc_inc;

  assign word_opc = imem_data[DW-1 -: OPC_W];
  assign word_opd = imem_data[AW-1:0];

  pc_counter #(
    .AW       (AW),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (word_opd),
    .pc       (pc)
  );

  // PC update: jumps in DECODE, sequential advance after JZ-not-taken or end of EXEC
  always_comb begin
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    case (state)
      S_DECODE: begin
        if (word_opc == OPC_JMP || (word_opc == OPC_JZ && zero)) begin
          pc_load = 1'b1;
        end else if (word_opc == OPC_JZ) begin
          pc_inc = 1'b1;
        end
      end
      S_EXEC: begin
        if (!stall && exec_cnt == '0) begin
          pc_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      imem_rd   <= 1'b0;
      imem_addr <= AW'(RESET_PC);
      opr       <= OPC_NOP;
      operand   <= '0;
      halt      <= 1'b0;
      exec_cnt  <= '0;
      op_q      <= OPC_NOP;
      opd_q     <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          imem_rd   <= 1'b1;
          imem_addr <= pc;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          imem_rd <= 1'b0;
          state   <= S_DECODE;
        end
        S_DECODE: begin
          if (word_opc == OPC_HALT) begin
            halt  <= 1'b1;
            state <= S_HALTED;
          end else if (word_opc == OPC_JMP || word_opc == OPC_JZ) begin
            state <= S_FETCH;
          end else begin
            op_q  <= word_opc;
            opd_q <= word_opd;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          opr      <= op_q;
          operand  <= opd_q;
          exec_cnt <= CW'(EXEC_CYCLES - 1);
          if (!stall) begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          opr     <= OPC_NOP;
          operand <= '0;
          if (!stall) begin
            if (exec_cnt == '0) begin
              state <= S_FETCH;
            end else begin
              exec_cnt <= exec_cnt - CW'(1);
            end
          end
        end
        S_HALTED: begin
          halt    <= 1'b1;
          opr     <= OPC_NOP;
          operand <= '0;
          imem_rd <= 1'b0;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a vector table of single-instruction programs
// plus hand-written sequences for multi-instruction, stall, EXEC_CYCLES=3, wrap and reset cases.
module tb_instr_sequencer;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;
  localparam logic [3:0]  NOP = 4'b0111;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          zero = 1'b0;
  logic          stall = 1'b0;
  logic [AW-1:0] imem_addr, imem_addr3;
  logic          imem_rd, imem_rd3;
  logic [DW-1:0] imem_data, imem_data3;
  logic [3:0]    opr, opr3;
  logic [AW-1:0] operand, operand3, pc, pc3;
  logic          halt, halt3;

  logic [DW-1:0] mem [0:4095];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_sequencer #(.AW(AW), .DW(DW), .EXEC_CYCLES(1), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
    .zero(zero), .stall(stall), .opr(opr), .operand(operand), .halt(halt), .pc(pc)
  );

  instr_sequencer #(.AW(AW), .DW(DW), .EXEC_CYCLES(3), .RESET_PC(0)) dut3 (
    .clk(clk), .rst(rst), .imem_addr(imem_addr3), .imem_rd(imem_rd3), .imem_data(imem_data3),
    .zero(zero), .stall(stall), .opr(opr3), .operand(operand3), .halt(halt3), .pc(pc3)
  );

  // Synchronous-read memory: data appears the cycle after the read strobe and is held
  always @(posedge clk) begin
    if (imem_rd)  imem_data  <= mem[imem_addr];
    if (imem_rd3) imem_data3 <= mem[imem_addr3];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Leaves rst released just after a negedge: that instant is step 0 (state FETCH)
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [15:0] word;
    logic        z;
    logic [11:0] exp_addr;
    logic [3:0]  exp_opr;
    logic [11:0] exp_opd;
    int          exp_issue;
    int          exp_gap;
    logic        exp_halt;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int first_rd, second_rd, issue_cnt, gap;
    logic [3:0]  seen_opr;
    logic [11:0] seen_opd, addr_at, pc_at;
    logic [3:0]  ops [$];
    logic [11:0] opds [$];
    logic [3:0]  opr_log [0:15];
    logic [11:0] pc_log [0:15];
    logic        rd_log [0:15];
    logic [11:0] addr_log [0:15];
    int          n_rd;

    vecs[0] = '{16'h0005, 1'b0, 12'h001, 4'h0, 12'h005, 1, 5, 1'b0};
    vecs[1] = '{16'h8003, 1'b0, 12'h001, 4'h8, 12'h003, 1, 5, 1'b0};
    vecs[2] = '{16'hC00A, 1'b0, 12'h00A, NOP,  12'h000, 0, 3, 1'b0};
    vecs[3] = '{16'hD020, 1'b1, 12'h020, NOP,  12'h000, 0, 3, 1'b0};
    vecs[4] = '{16'hD020, 1'b0, 12'h001, NOP,  12'h000, 0, 3, 1'b0};
    vecs[5] = '{16'hF000, 1'b0, 12'h000, NOP,  12'h000, 0, 0, 1'b1};
    vecs[6] = '{16'hEABC, 1'b1, 12'h001, 4'hE, 12'hABC, 1, 5, 1'b0};

    for (int i = 0; i < 4096; i++) mem[i] = 16'h7000;

    // Reset state
    do_reset();
    chk("reset_opr", 32'(opr), 32'(NOP));
    chk("reset_operand", 32'(operand), 0);
    chk("reset_halt", 32'(halt), 0);
    chk("reset_rd", 32'(imem_rd), 0);
    chk("reset_addr", 32'(imem_addr), 0);
    chk("reset_pc", 32'(pc), 0);

    // Single-instruction vectors: observe from first fetch to the next one
    for (int v = 0; v < 7; v++) begin
      mem[0] = vecs[v].word;
      mem[1] = 16'h7000;
      zero = vecs[v].z;
      do_reset();
      first_rd = -1; second_rd = -1; issue_cnt = 0;
      seen_opr = NOP; seen_opd = '0;
      addr_at = '0; pc_at = '0;
      for (int n = 1; n <= 16 && second_rd < 0; n++) begin
        @(negedge clk);
        if (opr !== NOP) begin
          issue_cnt++;
          seen_opr = opr;
          seen_opd = operand;
        end
        if (imem_rd === 1'b1) begin
          if (first_rd < 0) first_rd = n;
          else begin
            second_rd = n;
            addr_at = imem_addr;
            pc_at = pc;
          end
        end
      end
      if (second_rd < 0) begin
        addr_at = imem_addr;
        pc_at = pc;
      end
      gap = (second_rd < 0 || first_rd < 0) ? 0 : second_rd - first_rd;
      chk($sformatf("v%0d_first_rd", v), 32'(first_rd), 1);
      chk($sformatf("v%0d_gap", v), 32'(gap), 32'(vecs[v].exp_gap));
      chk($sformatf("v%0d_next_addr", v), 32'(addr_at), 32'(vecs[v].exp_addr));
      chk($sformatf("v%0d_pc", v), 32'(pc_at), 32'(vecs[v].exp_addr));
      chk($sformatf("v%0d_issue_cnt", v), 32'(issue_cnt), 32'(vecs[v].exp_issue));
      chk($sformatf("v%0d_opr", v), 32'(seen_opr), 32'(vecs[v].exp_opr));
      chk($sformatf("v%0d_operand", v), 32'(seen_opd), 32'(vecs[v].exp_opd));
      chk($sformatf("v%0d_halt", v), 32'(halt), 32'(vecs[v].exp_halt));
    end
    zero = 1'b0;

    // Three-instruction program ending in HALT
    mem[0] = 16'h0005; mem[1] = 16'h8003; mem[2] = 16'hF000;
    do_reset();
    ops.delete(); opds.delete();
    for (int n = 1; n <= 30 && halt !== 1'b1; n++) begin
      @(negedge clk);
      if (opr !== NOP) begin
        ops.push_back(opr);
        opds.push_back(operand);
      end
    end
    chk("prog_halt", 32'(halt), 1);
    chk("prog_issue_cnt", 32'(ops.size()), 2);
    if (ops.size() == 2) begin
      chk("prog_op0", 32'(ops[0]), 32'h0);
      chk("prog_opd0", 32'(opds[0]), 32'h5);
      chk("prog_op1", 32'(ops[1]), 32'h8);
      chk("prog_opd1", 32'(opds[1]), 32'h3);
    end
    chk("prog_halt_pc", 32'(pc), 2);
    n_rd = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (imem_rd !== 1'b0 || opr !== NOP || halt !== 1'b1 || pc !== 12'h002) n_rd++;
    end
    chk("halted_quiet_cycles_bad", 32'(n_rd), 0);

    // Stall held for 4 cycles while in ISSUE
    mem[0] = 16'h3007; mem[1] = 16'h7000;
    do_reset();
    for (int n = 1; n <= 12; n++) begin
      if (n == 4) stall = 1'b1;
      if (n == 8) stall = 1'b0;
      @(negedge clk);
      opr_log[n] = opr;
      pc_log[n] = pc;
      rd_log[n] = imem_rd;
    end
    stall = 1'b0;
    n_rd = 0;
    for (int n = 1; n <= 12; n++) if (opr_log[n] === 4'h3) n_rd++;
    chk("stall_opr_cycles", 32'(n_rd), 5);
    chk("stall_opr_first", 32'(opr_log[4]), 32'h3);
    chk("stall_opr_last", 32'(opr_log[8]), 32'h3);
    chk("stall_opr_after", 32'(opr_log[9]), 32'(NOP));
    chk("stall_pc_held", 32'(pc_log[8]), 0);
    chk("stall_pc_adv", 32'(pc_log[9]), 1);
    chk("stall_next_rd", 32'(rd_log[10]), 1);

    // EXEC_CYCLES=3 instance: one opcode cycle, three NOP cycles, then the next read
    mem[0] = 16'h2011; mem[1] = 16'h7000;
    do_reset();
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      opr_log[n] = opr3;
      rd_log[n] = imem_rd3;
      addr_log[n] = imem_addr3;
    end
    chk("ex3_opr", 32'(opr_log[4]), 32'h2);
    chk("ex3_nop_cycles", 32'({opr_log[5] === NOP, opr_log[6] === NOP, opr_log[7] === NOP}), 32'h7);
    chk("ex3_no_early_rd", 32'({rd_log[5], rd_log[6], rd_log[7]}), 0);
    chk("ex3_next_rd", 32'(rd_log[8]), 1);
    chk("ex3_next_addr", 32'(addr_log[8]), 1);

    // PC wrap: jump to 0xFFF, execute there, next fetch is address 0
    mem[0] = 16'hCFFF; mem[12'hFFF] = 16'h1001;
    do_reset();
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      rd_log[n] = imem_rd;
      addr_log[n] = imem_addr;
      pc_log[n] = pc;
    end
    chk("wrap_jmp_addr", 32'(addr_log[4]), 32'hFFF);
    chk("wrap_rd", 32'(rd_log[9]), 1);
    chk("wrap_addr", 32'(addr_log[9]), 0);
    chk("wrap_pc", 32'(pc_log[9]), 0);

    // Asynchronous reset in the middle of EXEC
    mem[0] = 16'hC010; mem[12'h010] = 16'h4005;
    do_reset();
    for (int n = 1; n <= 7; n++) @(negedge clk);
    chk("async_pre_opr", 32'(opr), 32'h4);
    chk("async_pre_pc", 32'(pc), 32'h010);
    rst = 1'b1;
    #1;
    chk("async_opr", 32'(opr), 32'(NOP));
    chk("async_pc", 32'(pc), 0);
    chk("async_operand", 32'(operand), 0);
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
